// File: rtl/grf_wb_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and the GRF write port.
// The arbiter takes the slave view; sources and the GRF together form the master view.
interface grf_wb_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [5*NREQ-1:0]    wa_in;
  logic [32*NREQ-1:0]   wd_in;
  logic [32*NREQ-1:0]   pc_in;
  logic [NREQ-1:0]      gnt;
  logic                 RWE;
  logic [4:0]           WA;
  logic [31:0]          WD;
  logic [31:0]          PC;
  logic                 busy;

  modport master (
    output req, wa_in, wd_in, pc_in,
    input  gnt, RWE, WA, WD, PC, busy
  );

  modport slave (
    input  req, wa_in, wd_in, pc_in,
    output gnt, RWE, WA, WD, PC, busy
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter owning the GRF write port; after reset it sweeps $1..$31 to zero
// before serving requesters. Grant is combinational, the GRF write is registered.
module grf_wb_arbiter #(
  parameter int unsigned NREQ           = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  grf_wb_arbiter_if.slave   bus
);

  localparam int unsigned PW = 2;

  typedef enum logic {S_CLEAR, S_RUN} state_e;
  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e          state_q, state_d;
  logic [4:0]      clr_cnt_q, clr_cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rwe_q, rwe_d;
  logic [4:0]      wa_q, wa_d;
  logic [31:0]     wd_q, wd_d;
  logic [31:0]     pc_q, pc_d;

  logic            found;
  logic [PW-1:0]   win;
  int unsigned     idx;
  logic [4:0]      wa_sel;
  logic [NREQ-1:0] gnt_d;

  // Rotating priority search starting at ptr_q
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign wa_sel = bus.wa_in[int'(win)*5 +: 5];

  always_comb begin
    gnt_d = '0;
    if (Reset && state_q == S_RUN && found) begin
      gnt_d[win] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    rwe_d     = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    pc_d      = pc_q;
    case (state_q)
      S_CLEAR: begin
        rwe_d     = 1'b1;
        wa_d      = clr_cnt_q;
        wd_d      = '0;
        pc_d      = '0;
        clr_cnt_d = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (found) begin
          ptr_d = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
          // A $0 destination is still granted but never reaches the port
          if (wa_sel != '0) begin
            rwe_d = 1'b1;
            wa_d  = wa_sel;
            wd_d  = bus.wd_in[int'(win)*32 +: 32];
            pc_d  = bus.pc_in[int'(win)*32 +: 32];
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= 5'd1;
      ptr_q     <= '0;
      rwe_q     <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      rwe_q     <= rwe_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.gnt  = gnt_d;
  assign bus.RWE  = rwe_q;
  assign bus.WA   = wa_q;
  assign bus.WD   = wd_q;
  assign bus.PC   = pc_q;
  assign bus.busy = (state_q == S_CLEAR);

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Owns the single GRF write port (RWE/WA/WD/PC) and shares it between NREQ writeback requesters, e.g. ALU result, load return and multiply/divide completion.
- Round-robin arbitration with a req/gnt handshake; the write to the register file is registered one cycle after grant.
- After reset, a clear sequencer writes zero to $1..$31 through the same port before any requester is served.
- Sits between the writeback sources and GRF; its outputs connect directly to GRF RWE/WA/WD/PC.

Parameters:
- NREQ, 3, number of writeback requesters; legal range 2..4.
- CLEAR_ON_RESET, 1, 1 = run the clear sweep after reset; 0 = enter RUN directly.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  request per source; held high with its wa_in/wd_in/pc_in stable until gnt.
- wa_in  input  5*NREQ  destination register per source; source i uses bits [5i+4:5i].
- wd_in  input  32*NREQ  write data per source; source i uses bits [32i+31:32i].
- pc_in  input  32*NREQ  PC of the writing instruction per source, used for the GRF trace.
- gnt  output  NREQ  one-hot, combinational; source i's request is accepted this cycle.
- RWE  output  1  registered GRF write enable.
- WA  output  5  registered GRF write address.
- WD  output  32  registered GRF write data.
- PC  output  32  registered PC forwarded to GRF.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (Reset=0, async):
  - State = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - clr_cnt=1, ptr=0.
  - RWE=0, WA=0, WD=0, PC=0, gnt=0.
  - busy=1 if CLEAR_ON_RESET=1, else 0.
- State CLEAR:
  - Each cycle registers RWE=1, WA=clr_cnt, WD=0, PC=0, then increments clr_cnt.
  - After issuing WA=31, moves to RUN at the next edge.
  - Takes exactly 31 cycles; busy=1 throughout; gnt=0 throughout, so requests wait.
- State RUN: arbitration each cycle.
  - Search req starting at index ptr, ascending, wrapping modulo NREQ. The first set bit k wins; gnt[k]=1 in the same cycle.
  - At the next edge: RWE<=1, WA<=wa_in[k], WD<=wd_in[k], PC<=pc_in[k], ptr<=(k+1) mod NREQ.
  - No req set: RWE<=0; WA/WD/PC hold their previous values; ptr unchanged.
- Latency and throughput:
  - Grant to GRF write is 1 cycle: the RWE pulse is visible in the cycle after gnt, and GRF commits at the following edge.
  - Sustained throughput is one write per cycle.
- $0 writes: a request with wa_in=0 is granted normally (gnt pulses, ptr advances), but RWE<=0 for that slot. The write is dropped at the port.
- Handshake rules:
  - gnt depends only on state, ptr and req; it never depends on wa_in/wd_in.
  - A source must sample gnt at the clock edge. After an accepted edge it may drop req or present a new request.
  - Deasserting req without a grant is legal; the request is withdrawn.
- Fairness: with all NREQ requesters continuously asserting, each is granted exactly once in every NREQ consecutive cycles.
- Reset mid-CLEAR or mid-RUN: immediately returns to the reset state. The clear sweep restarts from $1, and any pending registered write is discarded (RWE=0).
- WA/WD/PC change only on cycles where RWE is updated to 1 (CLEAR issue or RUN grant). They hold otherwise.

Test Plan:
- Reset release with CLEAR_ON_RESET=1 and req held at 3'b111:
  - RWE=1 for 31 cycles with WA=1..31, WD=0; busy=1 and gnt=0 throughout.
  - In the cycle busy falls, gnt=3'b001.
- Single source: req=3'b010, wa_in[1]=5'd8, wd_in[1]=32'hDEADBEEF, pc_in[1]=32'h00003008.
  - gnt=3'b010 in the same cycle.
  - Next cycle: RWE=1, WA=8, WD=32'hDEADBEEF, PC=32'h00003008.
- All three sources requesting continuously from ptr=0:
  - gnt sequence is 001, 010, 100, 001, 010, 100.
  - RWE stays high every cycle.
- $0 drop: source 0 requests wa_in=0, wd_in=32'h12345678.
  - gnt[0] pulses and ptr advances to 1.
  - Next cycle RWE=0; WA/WD keep their prior values.
- Withdrawal and wrap: ptr=2, req=3'b001.
  - gnt=3'b001 and ptr becomes 1.
  - req drops to 0 next cycle: gnt=0, then RWE=0.
- Reset asserted on clear cycle 10 (WA=10 issuing):
  - Outputs go 0 asynchronously.
  - After release, the sweep restarts at WA=1 and runs a full 31 cycles.
